// File: rtl/mux21_rr_arbiter.sv
// rtl/mux21_rr_arbiter.sv - round-robin arbiter driving a shared 2:1 mux path
// Registered grant/select with a per-grant burst limit; out_valid/out_data follow the owner's req combinationally.
module mux21_rr_arbiter #(
  parameter int W         = 8,
  parameter int MAX_BURST = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic         req1,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic         out_ready,
  output logic         gnt0,
  output logic         gnt1,
  output logic         sel,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

  typedef enum logic [1:0] {IDLE, G0, G1} state_t;

  state_t        state, state_nxt, other;
  logic          last, last_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          req_own, req_oth, beat;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last  <= 1'b1;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign gnt0      = (state == G0);
  assign gnt1      = (state == G1);
  assign sel       = (state == G1);
  assign out_valid = (gnt0 & req0) | (gnt1 & req1);
  assign beat      = out_valid & out_ready;
  assign out_data  = out_valid ? (sel ? d1 : d0) : '0;

  // last records the port that most recently gave up the channel
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    cnt_nxt   = cnt;
    req_own   = (state == G1) ? req1 : req0;
    req_oth   = (state == G1) ? req0 : req1;
    other     = (state == G1) ? G0 : G1;
    case (state)
      IDLE: begin
        if (req0 && req1)  state_nxt = last ? G0 : G1;
        else if (req0)     state_nxt = G0;
        else if (req1)     state_nxt = G1;
      end
      G0, G1: begin
        if (!req_own) begin
          state_nxt = req_oth ? other : IDLE;
          cnt_nxt   = '0;
          last_nxt  = (state == G1);
        end else if (beat && cnt == CNT_LAST) begin
          cnt_nxt = '0;
          if (req_oth) begin
            state_nxt = other;
            last_nxt  = (state == G1);
          end
        end else if (beat) begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mux21_rr_arbiter.sv
// tb/tb_mux21_rr_arbiter.sv - self-checking bench for mux21_rr_arbiter
// Behavioural owner/burst model plus a data scoreboard, directed scenarios then random traffic.
module tb_mux21_rr_arbiter;

  localparam int W    = 8;
  localparam int MAXB = 4;

  logic         clk = 1'b0;
  logic         rst, req0, req1, out_ready;
  logic [W-1:0] d0, d1;
  logic         gnt0, gnt1, sel, out_valid;
  logic [W-1:0] out_data;

  mux21_rr_arbiter #(.W(W), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .d0(d0), .d1(d1),
    .out_ready(out_ready), .gnt0(gnt0), .gnt1(gnt1), .sel(sel),
    .out_valid(out_valid), .out_data(out_data)
  );

  always #5 clk = ~clk;

  int           n_cmp = 0;
  int           n_bad = 0;
  logic [W-1:0] exp_q[$];
  int           m_own;    // 0 = nobody, 1 = port 0, 2 = port 1
  int           m_beats;
  bit           m_last;
  bit           rnd, hold0, hold1;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_valid();
    return (m_own == 1) ? req0 : (m_own == 2) ? req1 : 1'b0;
  endfunction

  task automatic model_edge();
    bit rx, ry;
    if (rst) begin
      m_own = 0; m_last = 1'b1; m_beats = 0;
      return;
    end
    if (m_own == 0) begin
      if (req0 && req1) m_own = m_last ? 1 : 2;
      else if (req0)    m_own = 1;
      else if (req1)    m_own = 2;
    end else begin
      rx = (m_own == 1) ? req0 : req1;
      ry = (m_own == 1) ? req1 : req0;
      if (!rx) begin
        m_last  = (m_own == 2);
        m_own   = ry ? 3 - m_own : 0;
        m_beats = 0;
      end else if (out_ready) begin
        m_beats++;
        if (m_beats == MAXB) begin
          m_beats = 0;
          if (ry) begin
            m_last = (m_own == 2);
            m_own  = 3 - m_own;
          end
        end
      end
    end
  endtask

  task automatic cyc(int n);
    for (int i = 0; i < n; i++) begin
      if (rnd) begin
        if (!hold0) d0 = W'($urandom);
        if (!hold1) d1 = W'($urandom);
      end
      if (model_valid()) exp_q.push_back((m_own == 1) ? d0 : d1);
      @(negedge clk);
      check("gnt0", gnt0, m_own == 1);
      check("gnt1", gnt1, m_own == 2);
      check("sel", sel, m_own == 2);
      check("out_valid", out_valid, model_valid());
      if (out_valid) begin
        if (exp_q.size() == 0) check("sb_underflow", exp_q.size(), 1);
        else                   check("out_data", out_data, exp_q.pop_front());
      end else begin
        check("out_data_zero", out_data, 0);
      end
      check("sb_drain", exp_q.size(), 0);
      exp_q.delete();
      hold0 = (m_own == 1) && req0 && !out_ready;
      hold1 = (m_own == 2) && req1 && !out_ready;
      @(posedge clk);
      model_edge();
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; out_ready = 1'b0;
    d0 = '0; d1 = '0; rnd = 1'b0; hold0 = 1'b0; hold1 = 1'b0;
    m_own = 0; m_last = 1'b1; m_beats = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_gnt0", gnt0, 0);
    check("rst_gnt1", gnt1, 0);
    check("rst_sel", sel, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);

    // single requester, one-cycle grant latency
    req0 = 1'b1; d0 = 8'hA5; out_ready = 1'b1;
    cyc(1);
    check("t1_gnt0", gnt0, 1);
    check("t1_gnt1", gnt1, 0);
    check("t1_out_valid", out_valid, 1);
    check("t1_out_data", out_data, 8'hA5);
    cyc(2);
    req0 = 1'b0;
    cyc(2);

    // simultaneous requests after reset: port 0 first, back-to-back bursts
    do_reset();
    rnd = 1'b1;
    req0 = 1'b1; req1 = 1'b1; out_ready = 1'b1;
    cyc(1);
    check("t2_first_g0", gnt0, 1);
    cyc(MAXB);
    check("t2_switch_g1", gnt1, 1);
    check("t2_switch_sel", sel, 1);
    cyc(MAXB);
    check("t2_back_g0", gnt0, 1);

    // lone owner keeps the grant across counter wrap
    req1 = 1'b0;
    cyc(10);
    check("t3_hold_g0", gnt0, 1);

    // stall in G1 with req0 waiting
    req0 = 1'b0; req1 = 1'b1;
    cyc(1);
    check("t6_drop_g1", gnt1, 1);
    cyc(2);
    rnd = 1'b0; d1 = 8'h3C; out_ready = 1'b0; req0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      check("t4_stall_g1", gnt1, 1);
      check("t4_stall_data", out_data, 8'h3C);
    end
    out_ready = 1'b1;
    cyc(1);
    check("t4_cnt3_g1", gnt1, 1);
    cyc(1);
    check("t4_burst_end_g0", gnt0, 1);

    // reset mid-burst in G1, then tie goes to port 0
    rnd = 1'b1;
    cyc(MAXB);
    check("t5_in_g1", gnt1, 1);
    cyc(2);
    rst = 1'b1;
    cyc(1);
    check("t5_rst_gnt0", gnt0, 0);
    check("t5_rst_gnt1", gnt1, 0);
    check("t5_rst_sel", sel, 0);
    check("t5_rst_valid", out_valid, 0);
    rst = 1'b0;
    cyc(1);
    check("t5_tie_g0", gnt0, 1);

    // req0 drop hands over; counter restarts for port 1
    cyc(1);
    req0 = 1'b0;
    cyc(1);
    check("t6_handover_g1", gnt1, 1);
    req0 = 1'b1;
    cyc(MAXB - 1);
    check("t6_full_burst_g1", gnt1, 1);
    cyc(1);
    check("t6_back_g0", gnt0, 1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      req0      = ($urandom_range(0, 3) != 0);
      req1      = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      rst       = ($urandom_range(0, 63) == 0);
      cyc(1);
      check("rnd_onehot", gnt0 & gnt1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
